mult_self_test: RTL

- Sequential self-test sequencer for the 2-bit combinational multiplier.
- Sits directly upstream of the multiplier and drives its a/b operand inputs. Also consumes its 4-bit product.
- Walks every operand pair, waits a settle time, compares the product against a golden a*b, and reports pass/fail, error count and the first failing pair.
- Used on the lab board to check the multiplier without toggling switches by hand.

---
 rtl/mult_self_test_if.sv | 25 ++
 rtl/mult_self_test.sv | 124 ++++++++++++
 2 files changed

// File: rtl/mult_self_test_if.sv
// Operand/product and status bundle between the self-test sequencer and its host/multiplier.
interface mult_self_test_if #(
    parameter int OP_W = 2
);
    logic                start;
    logic [OP_W-1:0]     a_out;
    logic [OP_W-1:0]     b_out;
    logic [2*OP_W-1:0]   product_in;
    logic                busy;
    logic                done;
    logic                pass;
    logic [2*OP_W:0]     err_count;
    logic [OP_W-1:0]     fail_a;
    logic [OP_W-1:0]     fail_b;

    modport master (
        input  start, product_in,
        output a_out, b_out, busy, done, pass, err_count, fail_a, fail_b
    );

    modport slave (
        output start, product_in,
        input  a_out, b_out, busy, done, pass, err_count, fail_a, fail_b
    );
endinterface

// File: rtl/mult_self_test.sv
// Self-test sequencer: walks every operand pair of the multiplier and checks each product.
// Optional macro MULT_ST_STOP_ON_FAIL_EN ends the run at the first mismatch.
module mult_self_test #(
    parameter int OP_W          = 2,
    parameter int SETTLE_CYCLES = 2
) (
    input  logic              clk,
    input  logic              rst_n,
    mult_self_test_if.master  bus
);
    localparam int IDX_W = 2 * OP_W;
    localparam int ERR_W = 2 * OP_W + 1;
    localparam int CNT_W = $clog2(SETTLE_CYCLES + 1);
    localparam logic [CNT_W-1:0] RELOAD = CNT_W'(SETTLE_CYCLES - 1);

    typedef enum logic [1:0] {IDLE, SETTLE, CHECK, DONE} state_t;

    state_t             state, state_n;
    logic [IDX_W-1:0]   idx, idx_n;
    logic [CNT_W-1:0]   cnt, cnt_n;
    logic [ERR_W-1:0]   err, err_n;
    logic [OP_W-1:0]    fa, fa_n, fb, fb_n;
    logic               pass_r, pass_n, done_r, done_n, busy_r, busy_n;

    logic [OP_W-1:0]    op_a, op_b;
    logic [IDX_W-1:0]   golden;
    logic               mismatch, finish;

    assign op_a     = idx[IDX_W-1:OP_W];
    assign op_b     = idx[OP_W-1:0];
    assign golden   = {{OP_W{1'b0}}, op_a} * {{OP_W{1'b0}}, op_b};
    assign mismatch = (bus.product_in != golden);

`ifdef MULT_ST_STOP_ON_FAIL_EN
    assign finish = (&idx) | mismatch;
`else
    assign finish = &idx;
`endif

    always_comb begin
        state_n = state;
        idx_n   = idx;
        cnt_n   = cnt;
        err_n   = err;
        fa_n    = fa;
        fb_n    = fb;
        pass_n  = pass_r;
        done_n  = done_r;
        busy_n  = busy_r;
        case (state)
            IDLE, DONE: begin
                if (bus.start) begin
                    idx_n   = '0;
                    cnt_n   = RELOAD;
                    err_n   = '0;
                    fa_n    = '0;
                    fb_n    = '0;
                    pass_n  = 1'b0;
                    done_n  = 1'b0;
                    busy_n  = 1'b1;
                    state_n = SETTLE;
                end
            end
            SETTLE: begin
                if (cnt == '0) state_n = CHECK;
                else           cnt_n   = cnt - CNT_W'(1);
            end
            CHECK: begin
                if (mismatch) begin
                    err_n = err + ERR_W'(1);
                    // Only the first failing pair is recorded.
                    if (err == '0) begin
                        fa_n = op_a;
                        fb_n = op_b;
                    end
                end
                if (finish) begin
                    state_n = DONE;
                    busy_n  = 1'b0;
                    done_n  = 1'b1;
                    pass_n  = (err_n == '0);
                end else begin
                    idx_n   = idx + IDX_W'(1);
                    cnt_n   = RELOAD;
                    state_n = SETTLE;
                end
            end
            default: state_n = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state  <= IDLE;
            idx    <= '0;
            cnt    <= '0;
            err    <= '0;
            fa     <= '0;
            fb     <= '0;
            pass_r <= 1'b0;
            done_r <= 1'b0;
            busy_r <= 1'b0;
        end else begin
            state  <= state_n;
            idx    <= idx_n;
            cnt    <= cnt_n;
            err    <= err_n;
            fa     <= fa_n;
            fb     <= fb_n;
            pass_r <= pass_n;
            done_r <= done_n;
            busy_r <= busy_n;
        end
    end

    assign bus.a_out     = op_a;
    assign bus.b_out     = op_b;
    assign bus.busy      = busy_r;
    assign bus.done      = done_r;
    assign bus.pass      = pass_r;
    assign bus.err_count = err;
    assign bus.fail_a    = fa;
    assign bus.fail_b    = fb;
endmodule
